// File: rtl/serial_adder_ctrl_if.sv
// Handshake, operand/result bus and full-adder cell hookup
// for the bit-serial add/subtract controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;

  modport master (
    output start, op, a, b,
    output fa_sum, fa_cout,
    input  busy, done, result,
    input  cout, overflow, zero,
    input  fa_a, fa_b, fa_cin
  );

  modport slave (
    input  start, op, a, b,
    input  fa_sum, fa_cout,
    output busy, done, result,
    output cout, overflow, zero,
    output fa_a, fa_b, fa_cin
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one bit per cycle
// through a shared external full-adder cell, LSB first.
module serial_adder_ctrl #(
  parameter int WIDTH = 24
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_run;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_res_next;

  assign w_run      = (r_state == RUN);
  assign w_shift    = {bus.fa_sum, r_res};
  assign w_res_next = w_shift[WIDTH:1];

  assign bus.busy     = w_run;
  assign bus.done     = (r_state == DONE);
  assign bus.result   = r_res;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
  assign bus.fa_a     = w_run & r_a[0];
  assign bus.fa_b     = w_run & r_b[0];
  assign bus.fa_cin   = w_run & r_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            // subtract as a + ~b + 1
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.op}};
            r_carry <= bus.op;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_next;
          r_carry <= bus.fa_cout;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_ovf   <= r_carry ^ bus.fa_cout;
            r_cout  <= bus.fa_cout;
            r_zero  <= (w_res_next == '0);
            r_state <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
